// File: rtl/sdma_chan_sequencer.sv
// rtl/sdma_chan_sequencer.sv - four-channel SDMA request sequencer with Wishbone register file
//
// Arbitrates fabric producer requests round-robin, keeps one SDMA channel in
// flight and walks it through Req/Sreq -> Active -> Done, with a watchdog.
// Ports:
//   WB_CLK, WB_RST_n          clock, asynchronous active-low reset
//   WBs_ADR/CYC/STB/WE        Wishbone slave address and cycle control
//   WBs_BYTE_STB, WBs_WR_DAT  byte enables and write data
//   WBs_RD_DAT, WBs_ACK       read data and one-cycle acknowledge
//   ch_req, ch_grant, ch_done producer request, one-hot grant, completion pulse
//   SDMA_Req, SDMA_Sreq       burst / single request to the cell
//   SDMA_Active, SDMA_Done    handshake from the cell
//   sdma_irq                  registered level interrupt
module sdma_chan_sequencer #(
    parameter int TIMEOUT_W = 16
) (
    input  logic        WB_CLK,
    input  logic        WB_RST_n,
    input  logic [2:0]  WBs_ADR,
    input  logic        WBs_CYC,
    input  logic        WBs_STB,
    input  logic        WBs_WE,
    input  logic [3:0]  WBs_BYTE_STB,
    input  logic [31:0] WBs_WR_DAT,
    output logic [31:0] WBs_RD_DAT,
    output logic        WBs_ACK,
    input  logic [3:0]  ch_req,
    output logic [3:0]  ch_grant,
    output logic [3:0]  ch_done,
    output logic [3:0]  SDMA_Req,
    output logic [3:0]  SDMA_Sreq,
    input  logic [3:0]  SDMA_Active,
    input  logic [3:0]  SDMA_Done,
    output logic        sdma_irq
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int TW1 = TIMEOUT_W + 1;
    // Only enable, single-mode and timeout bits exist in CTRL.
    localparam logic [31:0] CTRL_MASK =
        32'h0000_00FF | (((32'h1 << TIMEOUT_W) - 32'h1) << 16);
    localparam logic [31:0] IRQ_EN_MASK = 32'h0000_00FF;

    state_t               state;
    logic [1:0]           ptr;
    logic [1:0]           g_idx;
    logic [TIMEOUT_W-1:0] wd_cnt;
    logic [31:0]          ctrl_q;
    logic [31:0]          irq_en_q;
    logic [3:0]           done_sticky;
    logic [3:0]           to_sticky;
    logic [15:0]          done_cnt [4];

    logic [3:0]           enable;
    logic [3:0]           single;
    logic [TIMEOUT_W-1:0] timeout;

    assign enable  = ctrl_q[3:0];
    assign single  = ctrl_q[7:4];
    assign timeout = ctrl_q[TIMEOUT_W+15:16];

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic        wb_req;
    logic        wr_en;
    logic [31:0] wr_mask;
    logic [3:0]  clr_done;
    logic [3:0]  clr_to;
    logic [31:0] rd_mux;

    assign wb_req  = WBs_CYC & WBs_STB;
    // Writes land on the edge that ends the ACK cycle.
    assign wr_en   = wb_req & WBs_WE & WBs_ACK;
    assign wr_mask = {{8{WBs_BYTE_STB[3]}}, {8{WBs_BYTE_STB[2]}},
                      {8{WBs_BYTE_STB[1]}}, {8{WBs_BYTE_STB[0]}}};
    assign clr_done = (wr_en && WBs_ADR == 3'd1) ? (WBs_WR_DAT[7:4]  & wr_mask[7:4])  : 4'd0;
    assign clr_to   = (wr_en && WBs_ADR == 3'd1) ? (WBs_WR_DAT[11:8] & wr_mask[11:8]) : 4'd0;

    always_comb begin
        rd_mux = 32'd0;
        case (WBs_ADR)
            3'd0:    rd_mux = ctrl_q;
            3'd1:    rd_mux = {18'd0, state, to_sticky, done_sticky, ch_grant};
            3'd2:    rd_mux = irq_en_q;
            3'd4, 3'd5, 3'd6, 3'd7:
                     rd_mux = {16'd0, done_cnt[WBs_ADR[1:0]]};
            default: rd_mux = 32'd0;
        endcase
    end

    // ------------------------------------------------------------------
    // Round-robin pick, scanning from ptr upward with wrap
    // ------------------------------------------------------------------
    logic [3:0] eligible;
    logic       pick_valid;
    logic [1:0] pick_idx;
    logic [1:0] cand;
    logic [3:0] pick_onehot;

    always_comb begin
        eligible   = ch_req & enable;
        pick_valid = 1'b0;
        pick_idx   = ptr;
        cand       = ptr;
        // Descending scan so the smallest offset from ptr is the last to win.
        for (int i = 3; i >= 0; i--) begin
            cand = ptr + 2'(i);
            if (eligible[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
        pick_onehot = 4'b0001 << pick_idx;
    end

    // ------------------------------------------------------------------
    // In-flight channel qualifiers and events
    // ------------------------------------------------------------------
    logic           act_g;
    logic           done_g;
    logic           en_g;
    logic [TW1-1:0] wd_next;
    logic           wd_hit;
    logic           done_evt;
    logic           to_evt;

    assign act_g   = SDMA_Active[g_idx];
    assign done_g  = SDMA_Done[g_idx];
    assign en_g    = enable[g_idx];
    assign wd_next = {1'b0, wd_cnt} + TW1'(1);
    // >= rather than == so lowering the timeout mid-transfer still fires.
    assign wd_hit  = (timeout != '0) && (wd_next >= {1'b0, timeout});

    assign done_evt = (state == ST_DONE);
    // Forward progress takes priority over a watchdog expiry on the same edge.
    assign to_evt   = ((state == ST_REQ) && en_g && !act_g && wd_hit) ||
                      ((state == ST_ACTIVE) && !done_g && wd_hit);

    // ------------------------------------------------------------------
    // Channel FSM
    // ------------------------------------------------------------------
    always_ff @(posedge WB_CLK or negedge WB_RST_n) begin
        if (!WB_RST_n) begin
            state     <= ST_IDLE;
            ptr       <= 2'd0;
            g_idx     <= 2'd0;
            wd_cnt    <= '0;
            ch_grant  <= 4'd0;
            ch_done   <= 4'd0;
            SDMA_Req  <= 4'd0;
            SDMA_Sreq <= 4'd0;
        end else begin
            ch_done <= 4'd0;
            if (wd_cnt != '1 && (state == ST_REQ || state == ST_ACTIVE)) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        g_idx    <= pick_idx;
                        ch_grant <= pick_onehot;
                        if (single[pick_idx]) begin
                            SDMA_Sreq <= pick_onehot;
                        end else begin
                            SDMA_Req  <= pick_onehot;
                        end
                        ptr    <= pick_idx + 2'd1;
                        wd_cnt <= '0;
                        state  <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (!en_g || to_evt) begin
                        ch_grant  <= 4'd0;
                        SDMA_Req  <= 4'd0;
                        SDMA_Sreq <= 4'd0;
                        state     <= ST_IDLE;
                    end else if (act_g) begin
                        SDMA_Req  <= 4'd0;
                        SDMA_Sreq <= 4'd0;
                        state     <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (done_g) begin
                        ch_done <= ch_grant;
                        state   <= ST_DONE;
                    end else if (to_evt) begin
                        ch_grant <= 4'd0;
                        state    <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    ch_grant <= 4'd0;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Register file, status, counters, interrupt
    // ------------------------------------------------------------------
    always_ff @(posedge WB_CLK or negedge WB_RST_n) begin
        if (!WB_RST_n) begin
            WBs_ACK     <= 1'b0;
            WBs_RD_DAT  <= 32'd0;
            ctrl_q      <= 32'd0;
            irq_en_q    <= 32'd0;
            done_sticky <= 4'd0;
            to_sticky   <= 4'd0;
            sdma_irq    <= 1'b0;
            for (int c = 0; c < 4; c++) begin
                done_cnt[c] <= 16'd0;
            end
        end else begin
            WBs_ACK    <= wb_req & ~WBs_ACK;
            WBs_RD_DAT <= (wb_req & ~WBs_ACK) ? rd_mux : 32'd0;

            if (wr_en && WBs_ADR == 3'd0) begin
                ctrl_q <= ((ctrl_q & ~wr_mask) | (WBs_WR_DAT & wr_mask)) & CTRL_MASK;
            end
            if (wr_en && WBs_ADR == 3'd2) begin
                irq_en_q <= ((irq_en_q & ~wr_mask) | (WBs_WR_DAT & wr_mask)) & IRQ_EN_MASK;
            end

            // A set arriving with its own W1C survives.
            done_sticky <= (done_sticky & ~clr_done) | (done_evt ? ch_grant : 4'd0);
            to_sticky   <= (to_sticky & ~clr_to) | (to_evt ? ch_grant : 4'd0);

            for (int c = 0; c < 4; c++) begin
                if (wr_en && WBs_ADR == {1'b1, 2'(c)}) begin
                    done_cnt[c] <= (done_evt && ch_grant[c]) ? 16'd1 : 16'd0;
                end else if (done_evt && ch_grant[c] && done_cnt[c] != 16'hFFFF) begin
                    done_cnt[c] <= done_cnt[c] + 16'd1;
                end
            end

            sdma_irq <= |({to_sticky, done_sticky} & irq_en_q[7:0]);
        end
    end

endmodule

// File: tb/tb_sdma_chan_sequencer.sv
// tb/tb_sdma_chan_sequencer.sv - self-checking bench for sdma_chan_sequencer
module tb_sdma_chan_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  wb_adr = 3'd0;
    logic        wb_cyc = 1'b0;
    logic        wb_stb = 1'b0;
    logic        wb_we = 1'b0;
    logic [3:0]  wb_bs = 4'd0;
    logic [31:0] wb_wdat = 32'd0;
    logic [31:0] wb_rdat;
    logic        wb_ack;
    logic [3:0]  ch_req = 4'd0;
    logic [3:0]  ch_grant;
    logic [3:0]  ch_done;
    logic [3:0]  sdma_req;
    logic [3:0]  sdma_sreq;
    logic [3:0]  act_in;
    logic [3:0]  done_in;
    logic        sdma_irq;

    logic        model_on = 1'b0;
    logic [3:0]  man_active = 4'd0;
    logic [3:0]  man_done = 4'd0;
    logic [3:0]  m_active = 4'd0;
    logic [3:0]  m_done = 4'd0;
    logic [3:0]  m_ch = 4'd0;
    logic        m_busy = 1'b0;
    int          m_cnt = 0;

    int tests = 0;
    int fails = 0;

    assign act_in  = model_on ? m_active : man_active;
    assign done_in = model_on ? m_done   : man_done;

    always #5 clk = ~clk;

    sdma_chan_sequencer #(.TIMEOUT_W(16)) dut (
        .WB_CLK      (clk),
        .WB_RST_n    (rst_n),
        .WBs_ADR     (wb_adr),
        .WBs_CYC     (wb_cyc),
        .WBs_STB     (wb_stb),
        .WBs_WE      (wb_we),
        .WBs_BYTE_STB(wb_bs),
        .WBs_WR_DAT  (wb_wdat),
        .WBs_RD_DAT  (wb_rdat),
        .WBs_ACK     (wb_ack),
        .ch_req      (ch_req),
        .ch_grant    (ch_grant),
        .ch_done     (ch_done),
        .SDMA_Req    (sdma_req),
        .SDMA_Sreq   (sdma_sreq),
        .SDMA_Active (act_in),
        .SDMA_Done   (done_in),
        .sdma_irq    (sdma_irq)
    );

    // Cell model: Active two cycles after a request is seen, one-cycle Done after five.
    always begin
        @(posedge clk);
        #1;
        if (!model_on) begin
            m_busy = 1'b0; m_active = 4'd0; m_done = 4'd0; m_cnt = 0;
        end else if (m_busy) begin
            m_cnt++;
            if (m_cnt == 2) m_active = m_ch;
            if (m_cnt == 5) m_done = m_ch;
            if (m_cnt == 6) begin
                m_done = 4'd0; m_active = 4'd0; m_busy = 1'b0;
            end
        end else if ((sdma_req | sdma_sreq) != 4'd0) begin
            m_busy = 1'b1; m_cnt = 0; m_ch = sdma_req | sdma_sreq;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Bus tasks are entered and left 1 ns after a rising edge.
    task automatic wb_write(input logic [2:0] adr, input logic [31:0] dat, input logic [3:0] bs);
        bit seen = 0;
        wb_adr = adr; wb_wdat = dat; wb_bs = bs; wb_we = 1'b1; wb_cyc = 1'b1; wb_stb = 1'b1;
        for (int n = 0; n < 16 && !seen; n++) begin
            @(negedge clk);
            if (wb_ack) seen = 1;
        end
        if (!seen) check("wb_write_ack", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; wb_bs = 4'd0;
    endtask

    task automatic wb_read(input logic [2:0] adr, output logic [31:0] dat);
        bit seen = 0;
        dat = 32'hDEAD_BEEF;
        wb_adr = adr; wb_we = 1'b0; wb_cyc = 1'b1; wb_stb = 1'b1;
        for (int n = 0; n < 16 && !seen; n++) begin
            @(negedge clk);
            if (wb_ack) begin
                seen = 1;
                dat = wb_rdat;
            end
        end
        if (!seen) check("wb_read_ack", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        wb_cyc = 1'b0; wb_stb = 1'b0;
    endtask

    task automatic rd_check(input string name, input logic [2:0] adr, input logic [31:0] exp);
        logic [31:0] d;
        wb_read(adr, d);
        check(name, d, exp);
    endtask

    typedef struct {
        logic [2:0]  adr;
        logic        we;
        logic [3:0]  bs;
        logic [31:0] wdat;
        logic [31:0] exp;
    } reg_vec_t;

    reg_vec_t   vecs[$];
    logic [3:0] gseq [8];
    int         gcount;
    int         dcount;
    int         hi_cnt;
    logic [3:0] prev_grant;
    logic [3:0] prev_done;
    logic [31:0] rd;

    initial begin
        // Register vectors: reset reads, byte-strobe merges, RO/unmapped behaviour.
        for (int a = 0; a < 8; a++) vecs.push_back('{3'(a), 1'b0, 4'h0, 32'd0, 32'd0});
        vecs.push_back('{3'd0, 1'b1, 4'hF, 32'h1234_FFA5, 32'd0});
        vecs.push_back('{3'd0, 1'b0, 4'h0, 32'd0,        32'h1234_00A5});
        vecs.push_back('{3'd0, 1'b1, 4'h4, 32'hFFFF_FFFF, 32'd0});
        vecs.push_back('{3'd0, 1'b0, 4'h0, 32'd0,        32'h12FF_00A5});
        vecs.push_back('{3'd0, 1'b1, 4'hF, 32'd0,        32'd0});
        vecs.push_back('{3'd0, 1'b0, 4'h0, 32'd0,        32'd0});
        vecs.push_back('{3'd2, 1'b1, 4'hF, 32'hFFFF_FFFF, 32'd0});
        vecs.push_back('{3'd2, 1'b0, 4'h0, 32'd0,        32'h0000_00FF});
        vecs.push_back('{3'd2, 1'b1, 4'h1, 32'h0000_0000, 32'd0});
        vecs.push_back('{3'd2, 1'b0, 4'h0, 32'd0,        32'd0});
        vecs.push_back('{3'd1, 1'b1, 4'hF, 32'hFFFF_FFFF, 32'd0});
        vecs.push_back('{3'd1, 1'b0, 4'h0, 32'd0,        32'd0});
        vecs.push_back('{3'd3, 1'b1, 4'hF, 32'hFFFF_FFFF, 32'd0});
        vecs.push_back('{3'd3, 1'b0, 4'h0, 32'd0,        32'd0});

        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        check("reset_req",   {28'd0, sdma_req},  32'd0);
        check("reset_sreq",  {28'd0, sdma_sreq}, 32'd0);
        check("reset_grant", {28'd0, ch_grant},  32'd0);
        check("reset_done",  {28'd0, ch_done},   32'd0);
        check("reset_irq",   {31'd0, sdma_irq},  32'd0);
        check("reset_ack",   {31'd0, wb_ack},    32'd0);
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            if (vecs[i].we) begin
                wb_write(vecs[i].adr, vecs[i].wdat, vecs[i].bs);
            end else begin
                wb_read(vecs[i].adr, rd);
                check($sformatf("reg_vec[%0d]", i), rd, vecs[i].exp);
            end
        end

        // Round-robin with all four channels requesting and the cell model answering.
        wb_write(3'd0, 32'h0000_000F, 4'hF);
        model_on = 1'b1;
        ch_req = 4'hF;
        gcount = 0; dcount = 0; prev_grant = 4'd0; prev_done = 4'd0;
        for (int c = 0; c < 400 && dcount < 5; c++) begin
            @(negedge clk);
            if (ch_grant != prev_grant && ch_grant != 4'd0 && gcount < 8) begin
                gseq[gcount] = ch_grant;
                gcount++;
            end
            if (ch_done != 4'd0) begin
                check("rr_done_is_grant", {28'd0, ch_done}, {28'd0, ch_grant});
                check("rr_done_one_cycle", {28'd0, prev_done}, 32'd0);
                dcount++;
                if (dcount == 5) ch_req = 4'd0;
            end
            prev_grant = ch_grant;
            prev_done = ch_done;
        end
        check("rr_done_count", dcount, 5);
        check("rr_grant_count", gcount, 5);
        check("rr_grant0", {28'd0, gseq[0]}, 32'h1);
        check("rr_grant1", {28'd0, gseq[1]}, 32'h2);
        check("rr_grant2", {28'd0, gseq[2]}, 32'h4);
        check("rr_grant3", {28'd0, gseq[3]}, 32'h8);
        check("rr_grant4", {28'd0, gseq[4]}, 32'h1);
        @(posedge clk);
        #1;
        repeat (3) @(posedge clk);
        #1;
        model_on = 1'b0;
        check("rr_no_extra_grant", {28'd0, ch_grant}, 32'd0);
        rd_check("rr_cnt0", 3'd4, 32'd2);
        rd_check("rr_cnt1", 3'd5, 32'd1);
        rd_check("rr_cnt2", 3'd6, 32'd1);
        rd_check("rr_cnt3", 3'd7, 32'd1);
        rd_check("rr_status_sticky", 3'd1, 32'h0000_00F0);
        wb_write(3'd1, 32'h0000_0FF0, 4'hF);
        rd_check("rr_status_w1c", 3'd1, 32'd0);

        // Single mode on ch0: Sreq instead of Req, dropped after Active is sampled.
        wb_write(3'd0, 32'h0000_0011, 4'hF);
        ch_req = 4'h1;
        @(posedge clk);
        @(negedge clk);
        check("single_grant_latency", {28'd0, ch_grant}, 32'h1);
        check("single_sreq", {28'd0, sdma_sreq}, 32'h1);
        check("single_req_low", {28'd0, sdma_req}, 32'h0);
        @(posedge clk);
        #1;
        man_active = 4'h1;
        @(negedge clk);
        check("single_sreq_held", {28'd0, sdma_sreq}, 32'h1);
        @(negedge clk);
        check("single_sreq_dropped", {28'd0, sdma_sreq}, 32'h0);
        @(posedge clk);
        #1;
        man_done = 4'h1;
        ch_req = 4'd0;
        @(posedge clk);
        #1;
        man_done = 4'd0;
        man_active = 4'd0;
        @(negedge clk);
        check("single_done_pulse", {28'd0, ch_done}, 32'h1);
        @(posedge clk);
        #1;
        wb_write(3'd1, 32'h0000_0FF0, 4'hF);

        // Watchdog: timeout 8 on ch1 with no Active.
        wb_write(3'd0, 32'h0008_0002, 4'hF);
        ch_req = 4'h2;
        hi_cnt = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (ch_grant[1]) begin
                hi_cnt++;
            end else if (hi_cnt > 0) begin
                ch_req = 4'd0;
                break;
            end
        end
        check("wd_grant_cycles", hi_cnt, 8);
        check("wd_req_dropped", {28'd0, sdma_req}, 32'd0);
        @(posedge clk);
        #1;
        rd_check("wd_status", 3'd1, 32'h0000_0200);
        wb_write(3'd2, 32'h0000_0020, 4'hF);
        @(posedge clk);
        #1;
        check("wd_irq_set", {31'd0, sdma_irq}, 32'd1);
        wb_write(3'd1, 32'h0000_0200, 4'hF);
        @(posedge clk);
        #1;
        check("wd_irq_clear", {31'd0, sdma_irq}, 32'd0);
        rd_check("wd_status_clear", 3'd1, 32'd0);
        wb_write(3'd2, 32'd0, 4'hF);

        // Enable[2] cleared while in REQ aborts without a sticky bit.
        wb_write(3'd0, 32'h0000_0004, 4'hF);
        ch_req = 4'h4;
        @(posedge clk);
        #1;
        check("abort_grant", {28'd0, ch_grant}, 32'h4);
        wb_write(3'd0, 32'd0, 4'hF);
        @(posedge clk);
        #1;
        check("abort_grant_dropped", {28'd0, ch_grant}, 32'd0);
        rd_check("abort_status", 3'd1, 32'd0);

        // Enable[2] cleared while in ACTIVE: transfer still completes.
        wb_write(3'd0, 32'h0000_0004, 4'hF);
        @(posedge clk);
        #1;
        check("active_grant", {28'd0, ch_grant}, 32'h4);
        man_active = 4'h4;
        @(posedge clk);
        #1;
        ch_req = 4'd0;
        rd_check("active_status", 3'd1, 32'h0000_2004);
        wb_write(3'd0, 32'd0, 4'hF);
        man_done = 4'h4;
        @(posedge clk);
        #1;
        man_done = 4'd0;
        man_active = 4'd0;
        @(negedge clk);
        check("active_done_pulse", {28'd0, ch_done}, 32'h4);
        @(posedge clk);
        #1;
        rd_check("active_cnt2", 3'd6, 32'd2);
        rd_check("active_status_done", 3'd1, 32'h0000_0040);
        wb_write(3'd1, 32'h0000_0FF0, 4'hF);

        // W1C of done sticky[0] landing on the same edge as the sticky set.
        wb_write(3'd0, 32'h0000_0001, 4'hF);
        ch_req = 4'h1;
        @(posedge clk);
        #1;
        ch_req = 4'd0;
        man_active = 4'h1;
        @(posedge clk);
        #1;
        man_done = 4'h1;
        wb_write(3'd1, 32'h0000_0010, 4'hF);
        man_done = 4'd0;
        man_active = 4'd0;
        rd_check("w1c_vs_set", 3'd1, 32'h0000_0010);
        rd_check("cnt0_before_clear", 3'd4, 32'd4);
        wb_write(3'd1, 32'h0000_0FF0, 4'hF);

        // DONE_CNT[0] write landing on the same edge as the increment.
        ch_req = 4'h1;
        @(posedge clk);
        #1;
        ch_req = 4'd0;
        man_active = 4'h1;
        @(posedge clk);
        #1;
        man_done = 4'h1;
        wb_write(3'd4, 32'd0, 4'hF);
        man_done = 4'd0;
        man_active = 4'd0;
        rd_check("cnt_clear_vs_inc", 3'd4, 32'd1);

        // Asynchronous reset in the middle of a transfer.
        wb_write(3'd0, 32'h0000_0008, 4'hF);
        ch_req = 4'h8;
        @(posedge clk);
        @(negedge clk);
        check("arst_pre_grant", {28'd0, ch_grant}, 32'h8);
        check("arst_pre_req", {28'd0, sdma_req}, 32'h8);
        #2 rst_n = 1'b0;
        #1;
        check("arst_grant", {28'd0, ch_grant}, 32'd0);
        check("arst_req", {28'd0, sdma_req}, 32'd0);
        ch_req = 4'd0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        rd_check("arst_ctrl", 3'd0, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
